// File: rtl/set_scan_p.sv
// Lattice set-relation counter: scans a GRID x GRID lattice, tests up to NC circles per point and counts hits.
// Optional macro SET_PIPE_EN inserts a register between the distance compare and the accumulator.
module set_scan_p #(
    parameter int GRID = 8,
    parameter int CW   = 4,
    parameter int NC   = 3,
    localparam int CNTW = $clog2(GRID*GRID+1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [2*CW*NC-1:0]   central,
    input  logic [CW*NC-1:0]     radius,
    input  logic [1:0]           mode,
    output logic                 busy,
    output logic                 valid,
    output logic [CNTW-1:0]      candidate
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, OUT} state_t;

    state_t                state_q;
    logic                  busy_q;
    logic                  valid_q;
    logic [CNTW-1:0]       candidate_q;
    logic [CNTW-1:0]       accum_q;
    logic [CNTW-1:0]       accum_d;
    logic [CW-1:0]         xPos_q;
    logic [CW-1:0]         yPos_q;
    logic [2*CW*NC-1:0]    central_q;
    logic [CW*NC-1:0]      radius_q;
    logic [1:0]            mode_q;
    logic [NC-1:0]         membRaw;
    logic [2:0]            memb;
    logic                  hit;
    logic                  accumInc;
    logic                  lastPoint;
`ifdef SET_PIPE_EN
    logic                  pipeHit_q;
`endif

    // Operands are held for the whole job; they deliberately carry no reset.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && en) begin
            central_q <= central;
            radius_q  <= radius;
            mode_q    <= mode;
        end
    end

    for (genvar k = 0; k < NC; k++) begin : g_circle
        logic [CW-1:0]   cx, cy, rr, dx, dy;
        logic [2*CW-1:0] dx2, dy2, r2;
        logic [2*CW:0]   dist2;

        assign cx    = central_q[2*CW*(NC-k)-1 -: CW];
        assign cy    = central_q[2*CW*(NC-k)-CW-1 -: CW];
        assign rr    = radius_q[CW*(NC-k)-1 -: CW];
        assign dx    = (cx >= xPos_q) ? (cx - xPos_q) : (xPos_q - cx);
        assign dy    = (cy >= yPos_q) ? (cy - yPos_q) : (yPos_q - cy);
        assign dx2   = {{CW{1'b0}}, dx} * {{CW{1'b0}}, dx};
        assign dy2   = {{CW{1'b0}}, dy} * {{CW{1'b0}}, dy};
        assign r2    = {{CW{1'b0}}, rr} * {{CW{1'b0}}, rr};
        assign dist2 = {1'b0, dx2} + {1'b0, dy2};
        assign membRaw[k] = (dist2 <= {1'b0, r2});
    end

    always_comb begin
        memb = '0;
        for (int k = 0; k < NC; k++) begin
            memb[k] = membRaw[k];
        end
    end

    always_comb begin
        case (mode_q)
            2'd0:    hit = memb[0];
            2'd1:    hit = memb[0] & memb[1];
            2'd2:    hit = memb[0] ^ memb[1];
            default: hit = (memb == 3'b011) || (memb == 3'b101) || (memb == 3'b110);
        endcase
    end

    always_comb begin
`ifdef SET_PIPE_EN
        accumInc = pipeHit_q;
`else
        accumInc = (state_q == SCAN) && hit;
`endif
        accum_d   = accum_q + {{(CNTW-1){1'b0}}, accumInc};
        lastPoint = (xPos_q == CW'(GRID)) && (yPos_q == CW'(GRID));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            candidate_q <= '0;
            accum_q     <= '0;
            xPos_q      <= CW'(1);
            yPos_q      <= CW'(1);
`ifdef SET_PIPE_EN
            pipeHit_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_q   <= SCAN;
                        busy_q    <= 1'b1;
                        accum_q   <= '0;
                        xPos_q    <= CW'(1);
                        yPos_q    <= CW'(1);
`ifdef SET_PIPE_EN
                        pipeHit_q <= 1'b0;
`endif
                    end
                end
                SCAN: begin
                    accum_q <= accum_d;
`ifdef SET_PIPE_EN
                    pipeHit_q <= hit;
`endif
                    // x is the inner loop, y the outer loop.
                    if (xPos_q == CW'(GRID)) begin
                        xPos_q <= CW'(1);
                        yPos_q <= (yPos_q == CW'(GRID)) ? CW'(1) : yPos_q + CW'(1);
                    end else begin
                        xPos_q <= xPos_q + CW'(1);
                    end
                    if (lastPoint) begin
`ifdef SET_PIPE_EN
                        state_q     <= DRAIN;
`else
                        state_q     <= OUT;
                        valid_q     <= 1'b1;
                        candidate_q <= accum_d;
`endif
                    end
                end
`ifdef SET_PIPE_EN
                DRAIN: begin
                    accum_q     <= accum_d;
                    pipeHit_q   <= 1'b0;
                    state_q     <= OUT;
                    valid_q     <= 1'b1;
                    candidate_q <= accum_d;
                end
`endif
                OUT: begin
                    state_q     <= IDLE;
                    valid_q     <= 1'b0;
                    candidate_q <= '0;
                    busy_q      <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign valid     = valid_q;
    assign candidate = candidate_q;

endmodule

// File: doc/set_scan_p.md
# set_scan_p

Parametrised successor to the three-circle candidate counter. The block accepts up to NC circles (centre and radius) plus a mode in one handshake cycle. It scans a GRID×GRID lattice with all circles evaluated in parallel, one lattice point per cycle, and returns the number of lattice points satisfying the selected set relation. It sits behind the same host that drives `en`/`busy`/`valid` on the existing circle-set block.

## Interface
- GRID, 8: lattice side; points are x,y ∈ 1..GRID; GRID ≤ 2^CW − 1.
- CW, 4: coordinate/radius width in bits.
- NC, 3: circle count, legal values 1, 2 or 3.
- CNTW, $clog2(GRID*GRID+1): candidate width (derived, do not override).
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  load strobe; sampled only while busy=0.
- central  in  2*CW*NC  circle k centre: x at [2CW(NC−k)−1 -: CW], y in the next CW bits below; circle 0 is the MSB pair.
- radius  in  CW*NC  circle k radius, circle 0 in the MSBs.
- mode  in  2  0: in A; 1: A∧B; 2: A⊕B; 3: exactly two of A,B,C.
- busy  out  1  high from the cycle after load until the cycle after valid.
- valid  out  1  one-cycle result strobe.
- candidate  out  CNTW  result while valid=1, else 0.

## Operation
- States: IDLE → SCAN → (DRAIN, SET_PIPE_EN only) → OUT → IDLE.
- IDLE: busy=0. en=1 registers central, radius and mode, clears the accumulator, sets x=y=1 and moves to SCAN. Later input changes have no effect until the next load.
- SCAN: each cycle computes membership m[k] = (dx²+dy² ≤ r_k²) for every circle, where dx=|cx_k−x| and dy=|cy_k−y|.
  - dx, dy: CW bits. Squares: 2CW bits. Sum: 2CW+1 bits. No truncation.
  - Circles with index ≥ NC count as m=0.
- Per-point hit by mode:
  - mode 0: m0.
  - mode 1: m0&m1.
  - mode 2: m0^m1.
  - mode 3: popcount(m)==2.
- Each hit increments the accumulator (CNTW bits, cannot overflow).
- Scan order: x is the inner loop 1..GRID, y the outer loop. SCAN exits after point (GRID,GRID).
- OUT: valid=1, candidate=accumulator, busy=1. Next state is IDLE.
- en while busy=1 is ignored; a new job needs en in IDLE.
- Reset (any state, asynchronous): state=IDLE, busy=0, valid=0, candidate=0, accumulator=0, x=y=1. Registered operands are not reset.

## Timing
- Load edge = cycle 0. SCAN occupies cycles 1..GRID². OUT (valid=1) is at cycle GRID²+1, or GRID²+2 with SET_PIPE_EN. busy falls the following cycle.
- busy is registered. The earliest next load is the first cycle busy=0, giving a back-to-back throughput of one job per GRID²+2 cycles (+1 with pipe).
- All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.

## Configuration
- SET_PIPE_EN defined:
  - Adds a register stage between the squared-distance compare and the accumulator.
  - Adds a one-cycle DRAIN state after SCAN to commit the last point.
  - Latency increases by 1; counts are identical.
- SET_PIPE_EN undefined:
  - Compare and accumulate happen in the same cycle.
  - No DRAIN state.

## Test plan
- GRID=8, CW=4, NC=3, mode 0, A=(4,4) r=0 → candidate=1; valid at cycle 65 after the load edge; busy high cycles 1..65.
- mode 0, A=(4,4) r=2 → 13; then A=(1,1) r=8 (clipped at the corner) → 56.
- A=(4,4) r=1, B=(5,4) r=1: mode 1 → 2; mode 2 → 6.
- mode 3, A=(4,4) r=1, B=(5,4) r=1, C=(4,4) r=0 → 1, since only (5,4) lies in exactly two circles.
- en pulsed with different operands at cycle 20 of a job → ignored; result unchanged. A fresh load in the first idle cycle is accepted.
- rst_n low at cycle 30 of a scan → busy, valid and candidate are 0 immediately. A new job after release returns the correct count. Repeat every case with SET_PIPE_EN defined and expect valid one cycle later.
